// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared ALU opcodes, flag layout and branch funct3 encodings
package branch_resolver_pkg;

  typedef enum logic [2:0] {
    AddOp = 3'd0,
    SubOp = 3'd1,
    AndOp = 3'd2,
    OrOp  = 3'd3,
    XorOp = 3'd4
  } ALU_Ops;

  localparam int FlagSize = 4;
  localparam int FlagV    = 3;
  localparam int FlagN    = 2;
  localparam int FlagC    = 1;
  localparam int FlagZ    = 0;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_resolver_cond.sv
// rtl/branch_resolver_cond.sv - taken/illegal decision from funct3 and subtraction flags
module branch_cond
  import branch_resolver_pkg::*;
(
  input  logic [2:0]          funct3_i,
  input  logic [FlagSize-1:0] flags_i,
  output logic                taken_o,
  output logic                illegal_o
);

  logic signed_lt;

  assign signed_lt = flags_i[FlagN] ^ flags_i[FlagV];

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = flags_i[FlagZ];
      F3_BNE:  taken_o = ~flags_i[FlagZ];
      F3_BLT:  taken_o = signed_lt;
      F3_BGE:  taken_o = ~signed_lt;
      // C is the borrow, so it is set exactly when rs1 < rs2 unsigned
      F3_BLTU: taken_o = flags_i[FlagC];
      F3_BGEU: taken_o = ~flags_i[FlagC];
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - conditional branch resolution sequenced over an external ALU
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output ALU_Ops                alu_op_o,
  input  logic [DATA_WIDTH-1:0] alu_y_i,
  input  logic [FlagSize-1:0]   alu_flags_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  taken_o,
  output logic                  illegal_o,
  output logic                  misaligned_o,
  output logic [DATA_WIDTH-1:0] target_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_TGT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
  logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  taken_q, taken_d;
  logic                  illegal_q, illegal_d;
  logic                  misaligned_q, misaligned_d;

  logic cond_taken;
  logic cond_illegal;
  logic accept;

  branch_cond u_cond (
    .funct3_i  (funct3_q),
    .flags_i   (alu_flags_i),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  assign accept = (state_q == S_IDLE) && start_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_CMP;
      S_CMP:   state_d = S_TGT;
      S_TGT:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = 1'b1;
    done_o   = 1'b0;
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = AddOp;
    case (state_q)
      S_IDLE: busy_o = 1'b0;
      S_CMP: begin
        alu_a_o  = rs1_q;
        alu_b_o  = rs2_q;
        alu_op_o = SubOp;
      end
      S_TGT: begin
        alu_a_o = pc_q;
        alu_b_o = taken_q ? imm_q : DATA_WIDTH'(4);
      end
      S_DONE:  done_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  always_comb begin
    funct3_d     = funct3_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    taken_d      = taken_q;
    illegal_d    = illegal_q;
    target_d     = target_q;
    misaligned_d = misaligned_q;
    if (accept) begin
      funct3_d = funct3_i;
      rs1_d    = rs1_i;
      rs2_d    = rs2_i;
      pc_d     = pc_i;
      imm_d    = imm_i;
    end
    if (state_q == S_CMP) begin
      taken_d   = cond_taken;
      illegal_d = cond_illegal;
    end
    if (state_q == S_TGT) begin
      target_d     = alu_y_i;
      misaligned_d = taken_q && (|alu_y_i[1:0]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      funct3_q     <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      taken_q      <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      funct3_q     <= funct3_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      taken_q      <= taken_d;
      illegal_q    <= illegal_d;
      target_q     <= target_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign taken_o      = taken_q;
  assign illegal_o    = illegal_q;
  assign misaligned_o = misaligned_q;
  assign target_o     = target_q;

endmodule
